// File: rtl/anc_spi_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module      : anc_spi_frame_sched
//  Description : SPI master sequencer shared by two requesters (ch0 = ADC
//                read, ch1 = DAC write) with round-robin arbitration.
//                Shifts a FRAME_BITS word out MSB first on MOSI with an
//                idle-high SCK. Returns the low DATA_BITS of the captured
//                MISO frame to the channel that won the link.
//  Revision    : 1.0 - initial release
// ============================================================================
module anc_spi_frame_sched #(
    parameter int FRAME_BITS = 20,
    parameter int DATA_BITS  = 11,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  Clk_i,
    input  logic                  Reset_i,
    input  logic [1:0]            Req_i,
    input  logic [FRAME_BITS-1:0] TxWord0_i,
    input  logic [FRAME_BITS-1:0] TxWord1_i,
    output logic [1:0]            Gnt_o,
    output logic                  SCK_o,
    output logic                  MOSI_o,
    input  logic                  MISO_i,
    output logic                  CS_n_o,
    output logic [DATA_BITS-1:0]  RxData_o,
    output logic                  RxValid_o,
    output logic                  RxChan_o,
    output logic                  Busy_o
);

    // One shared down-phase counter serves SETUP, each SCK half-period and GAP,
    // so it must hold the larger of CLK_DIV and GAP_CYCLES without wrapping.
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [CNT_W-1:0] c_DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(FRAME_BITS - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SETUP = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;
    localparam logic [1:0] c_ST_GAP   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  half_q, half_d;     // 0 = SCK high phase, 1 = low phase
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [DATA_BITS-1:0]  rx_q, rx_d;
    logic                  last_q, last_d;     // channel granted most recently
    logic [DATA_BITS-1:0]  rxdata_q, rxdata_d;
    logic                  rxchan_q, rxchan_d;
    logic                  rxvalid_q, rxvalid_d;

    logic w_accept;
    logic w_win_ch;
    logic w_div_done;
    logic w_gap_done;
    logic w_sample;
    logic w_bit_end;
    logic w_frame_end;

    // A frame is accepted only from IDLE and never while reset is asserted,
    // so Gnt cannot pulse for a frame that the reset would discard.
    assign w_accept = (state_q == c_ST_IDLE) && Reset_i && (Req_i != 2'b00);

    // Contention goes to the channel that was not served last; a lone
    // request always wins regardless of the pointer.
    assign w_win_ch = (Req_i == 2'b11) ? ~last_q : Req_i[1];

    assign w_div_done  = (cnt_q == c_DIV_LAST);
    assign w_gap_done  = (cnt_q == c_GAP_LAST);
    assign w_sample    = (state_q == c_ST_SHIFT) && !half_q && w_div_done;
    assign w_bit_end   = (state_q == c_ST_SHIFT) &&  half_q && w_div_done;
    assign w_frame_end = w_bit_end && (bit_q == c_BIT_LAST);

    // State register
    always_ff @(posedge Clk_i) begin
        if (!Reset_i) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> SETUP -> SHIFT -> GAP -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  if (w_accept)    state_d = c_ST_SETUP;
            c_ST_SETUP: if (w_div_done)  state_d = c_ST_SHIFT;
            c_ST_SHIFT: if (w_frame_end) state_d = c_ST_GAP;
            c_ST_GAP:   if (w_gap_done)  state_d = c_ST_IDLE;
            default:                     state_d = c_ST_IDLE;
        endcase
    end

    // Output decode: SCK/CS_n/MOSI follow state so reset forces idle levels at once
    always_comb begin
        Gnt_o  = 2'b00;
        CS_n_o = 1'b1;
        SCK_o  = 1'b1;
        MOSI_o = 1'b0;
        Busy_o = (state_q != c_ST_IDLE);
        if (w_accept) begin
            Gnt_o = w_win_ch ? 2'b10 : 2'b01;
        end
        case (state_q)
            c_ST_SETUP: begin
                CS_n_o = 1'b0;
                MOSI_o = tx_q[FRAME_BITS-1];
            end
            c_ST_SHIFT: begin
                CS_n_o = 1'b0;
                SCK_o  = ~half_q;
                MOSI_o = tx_q[FRAME_BITS-1];
            end
            default: begin
                CS_n_o = 1'b1;
            end
        endcase
    end

    // Datapath next-state: phase counting, shifting and result capture
    always_comb begin
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        half_d    = half_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        last_d    = last_q;
        rxdata_d  = rxdata_q;
        rxchan_d  = rxchan_q;
        rxvalid_d = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                cnt_d  = '0;
                bit_d  = '0;
                half_d = 1'b0;
                if (w_accept) begin
                    tx_d   = w_win_ch ? TxWord1_i : TxWord0_i;
                    rx_d   = '0;
                    last_d = w_win_ch;
                end
            end
            c_ST_SETUP: begin
                cnt_d = w_div_done ? '0 : cnt_q + 1'b1;
            end
            c_ST_SHIFT: begin
                if (w_div_done) begin
                    cnt_d  = '0;
                    half_d = ~half_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                // MISO is taken just before SCK falls
                if (w_sample) begin
                    rx_d = (rx_q << 1) | DATA_BITS'(MISO_i);
                end
                // Advancing the word here makes MOSI change only as SCK rises
                if (w_bit_end) begin
                    tx_d  = tx_q << 1;
                    bit_d = bit_q + 1'b1;
                end
                if (w_frame_end) begin
                    bit_d     = '0;
                    rxvalid_d = 1'b1;
                    rxdata_d  = rx_q;
                    rxchan_d  = last_q;
                end
            end
            c_ST_GAP: begin
                cnt_d = w_gap_done ? '0 : cnt_q + 1'b1;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath registers; the RR pointer resets to "ch1 last" so ch0 wins first
    always_ff @(posedge Clk_i) begin
        if (!Reset_i) begin
            cnt_q     <= '0;
            bit_q     <= '0;
            half_q    <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            last_q    <= 1'b1;
            rxdata_q  <= '0;
            rxchan_q  <= 1'b0;
            rxvalid_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            half_q    <= half_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            last_q    <= last_d;
            rxdata_q  <= rxdata_d;
            rxchan_q  <= rxchan_d;
            rxvalid_q <= rxvalid_d;
        end
    end

    assign RxData_o  = rxdata_q;
    assign RxChan_o  = rxchan_q;
    assign RxValid_o = rxvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_anc_spi_frame_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_anc_spi_frame_sched
//  Description : Self-checking bench for anc_spi_frame_sched. A default
//                instance talks to a behavioural SPI slave; a second
//                instance runs with CLK_DIV=1, GAP_CYCLES=1 and MISO tied high.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_anc_spi_frame_sched;

    localparam int FB = 20;
    localparam int DB = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [1:0]    req_f = 2'b00;
    logic [FB-1:0] tx0 = '0;
    logic [FB-1:0] tx1 = '0;
    logic          loop_mode = 1'b0;
    logic          slv_miso = 1'b0;
    logic          miso;

    logic [1:0]    gnt, gnt_f;
    logic          sck, mosi, cs_n, rxv, rxch, busy;
    logic          sck_f, mosi_f, cs_n_f, rxv_f, rxch_f, busy_f;
    logic [DB-1:0] rxd, rxd_f;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int sck_viol = 0;

    anc_spi_frame_sched u_dut (
        .Clk_i(clk), .Reset_i(rst_n), .Req_i(req),
        .TxWord0_i(tx0), .TxWord1_i(tx1),
        .Gnt_o(gnt), .SCK_o(sck), .MOSI_o(mosi), .MISO_i(miso), .CS_n_o(cs_n),
        .RxData_o(rxd), .RxValid_o(rxv), .RxChan_o(rxch), .Busy_o(busy)
    );

    anc_spi_frame_sched #(.FRAME_BITS(20), .DATA_BITS(11), .CLK_DIV(1), .GAP_CYCLES(1)) u_fast (
        .Clk_i(clk), .Reset_i(rst_n), .Req_i(req_f),
        .TxWord0_i(tx0), .TxWord1_i(tx1),
        .Gnt_o(gnt_f), .SCK_o(sck_f), .MOSI_o(mosi_f), .MISO_i(1'b1), .CS_n_o(cs_n_f),
        .RxData_o(rxd_f), .RxValid_o(rxv_f), .RxChan_o(rxch_f), .Busy_o(busy_f)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SPI slave: shifts its word out MSB first, changing after
    // each SCK fall, and captures MOSI on each SCK fall.
    logic [FB-1:0] slv_next = '0;
    logic [FB-1:0] slv_word = '0;
    logic [FB-1:0] slv_rx   = '0;
    int            slv_falls = 0;

    always @(negedge cs_n) begin
        slv_word  = slv_next;
        slv_rx    = '0;
        slv_falls = 0;
        slv_miso  = slv_next[FB-1];
    end

    always @(negedge sck) begin
        if (!cs_n) begin
            slv_rx = {slv_rx[FB-2:0], mosi};
            slv_falls++;
            if (slv_falls < FB) slv_miso = slv_word[FB-1-slv_falls];
        end
    end

    assign miso = loop_mode ? mosi : slv_miso;

    // SCK must stay high whenever the slave is deselected
    always @(negedge clk) begin
        if (cs_n === 1'b1 && sck === 1'b0) sck_viol++;
        if (cs_n_f === 1'b1 && sck_f === 1'b0) sck_viol++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One complete frame from IDLE: grant, latency, data, ownership, gap
    task automatic run_frame(input string nm, input logic [1:0] rq,
                             input logic [FB-1:0] w0, input logic [FB-1:0] w1,
                             input logic [FB-1:0] sw, input logic [1:0] eg,
                             input logic [DB-1:0] erx, input logic ech,
                             input logic [FB-1:0] etx);
        int t0, k, extra;
        @(posedge clk); #1;
        req = rq; tx0 = w0; tx1 = w1; slv_next = sw;
        @(negedge clk);
        check({nm, "/gnt"}, 32'(gnt), 32'(eg));
        t0 = cyc;
        @(posedge clk); #1;
        req = 2'b00; tx0 = FB'($urandom); tx1 = FB'($urandom);
        k = 0; extra = 0;
        do begin
            @(negedge clk); k++;
            if (gnt != 2'b00) extra++;
        end while (!rxv && k < 400);
        check({nm, "/rxvalid_seen"}, 32'(rxv), 32'd1);
        check({nm, "/rx_latency"}, cyc - t0, 165);
        check({nm, "/rxdata"}, 32'(rxd), 32'(erx));
        check({nm, "/rxchan"}, 32'(rxch), 32'(ech));
        check({nm, "/mosi_word"}, 32'(slv_rx), 32'(etx));
        check({nm, "/sck_falls"}, slv_falls, FB);
        check({nm, "/gnt_quiet"}, extra, 0);
        k = 0;
        do begin @(negedge clk); k++; end while (busy && k < 10);
        check({nm, "/idle_at"}, cyc - t0, 167);
    endtask

    typedef struct {
        logic [1:0]    req;
        logic [FB-1:0] w0;
        logic [FB-1:0] w1;
        logic [FB-1:0] sw;
        logic          lp;
        logic [1:0]    eg;
        logic [DB-1:0] erx;
        logic          ech;
        logic [FB-1:0] etx;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int t0, k, prev, early, rxcnt;
        logic [1:0]    rq, eg;
        logic [FB-1:0] w0, w1, sw;
        logic          ch, mdl_last;

        // Expected values worked by hand; RR pointer starts favouring ch0
        vecs[0] = '{2'b01, 20'h805A5, 20'h00000, 20'h00000, 1'b1, 2'b01, 11'h5A5, 1'b0, 20'h805A5};
        vecs[1] = '{2'b10, 20'h00000, 20'h12345, 20'hABCDE, 1'b0, 2'b10, 11'h4DE, 1'b1, 20'h12345};
        vecs[2] = '{2'b11, 20'h0F0F0, 20'hFFFFF, 20'hFFFFF, 1'b0, 2'b01, 11'h7FF, 1'b0, 20'h0F0F0};
        vecs[3] = '{2'b11, 20'h11111, 20'h3C3C3, 20'h00000, 1'b0, 2'b10, 11'h000, 1'b1, 20'h3C3C3};
        vecs[4] = '{2'b11, 20'h80000, 20'h00001, 20'h55555, 1'b0, 2'b01, 11'h555, 1'b0, 20'h80000};
        vecs[5] = '{2'b01, 20'h00001, 20'h77777, 20'hAAAAA, 1'b0, 2'b01, 11'h2AA, 1'b0, 20'h00001};
        vecs[6] = '{2'b10, 20'h13579, 20'hFFFFF, 20'h00000, 1'b1, 2'b10, 11'h7FF, 1'b1, 20'hFFFFF};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst/cs_n", 32'(cs_n), 32'd1);
        check("rst/sck", 32'(sck), 32'd1);
        check("rst/mosi", 32'(mosi), 32'd0);
        check("rst/gnt", 32'(gnt), 32'd0);
        check("rst/rxvalid", 32'(rxv), 32'd0);
        check("rst/rxdata", 32'(rxd), 32'd0);
        check("rst/rxchan", 32'(rxch), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Fast instance: CLK_DIV=1, GAP_CYCLES=1, MISO=1
        tx0 = 20'h80000;
        @(posedge clk); #1 req_f = 2'b01;
        @(negedge clk);
        check("fast/gnt", 32'(gnt_f), 32'd1);
        t0 = cyc;
        @(posedge clk); #1;
        check("fast/busy", 32'(busy_f), 32'd1);
        check("fast/cs_n", 32'(cs_n_f), 32'd0);
        check("fast/mosi_msb", 32'(mosi_f), 32'd1);
        k = 0;
        do begin @(negedge clk); k++; end while (!rxv_f && k < 100);
        check("fast/rx_latency", cyc - t0, 42);
        check("fast/rxdata", 32'(rxd_f), 32'h7FF);
        check("fast/rxchan", 32'(rxch_f), 32'd0);
        k = 0;
        do begin @(negedge clk); k++; end while (gnt_f == 2'b00 && k < 20);
        check("fast/next_gnt", cyc - t0, 43);
        @(posedge clk); #1 req_f = 2'b00;
        k = 0;
        do begin @(negedge clk); k++; end while (busy_f && k < 100);
        check("fast/idle", 32'(busy_f), 32'd0);

        // Table-driven frames on the default instance
        for (int i = 0; i < 7; i++) begin
            loop_mode = vecs[i].lp;
            run_frame($sformatf("vec%0d", i), vecs[i].req, vecs[i].w0, vecs[i].w1, vecs[i].sw,
                      vecs[i].eg, vecs[i].erx, vecs[i].ech, vecs[i].etx);
        end
        loop_mode = 1'b0;

        // Both requests held from reset: grants alternate, 167 cycles apart
        @(posedge clk); #1 rst_n = 1'b0; req = 2'b11; slv_next = FB'($urandom);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        prev = 0;
        for (int g = 0; g < 4; g++) begin
            k = 0;
            do begin @(negedge clk); k++; end while (gnt == 2'b00 && k < 400);
            check("rr/gnt", 32'(gnt), (g % 2 == 0) ? 32'd1 : 32'd2);
            if (g > 0) check("rr/spacing", cyc - prev, 167);
            prev = cyc;
        end
        @(posedge clk); #1 req = 2'b00;
        k = 0;
        do begin @(negedge clk); k++; end while (busy && k < 400);
        check("rr/idle", 32'(busy), 32'd0);

        // Req1 raised mid-frame is held off until IDLE
        @(posedge clk); #1 req = 2'b01; slv_next = FB'($urandom);
        @(negedge clk);
        check("late/gnt0", 32'(gnt), 32'd1);
        t0 = cyc;
        @(posedge clk); #1 req = 2'b00;
        repeat (49) @(posedge clk);
        #1 req = 2'b10;
        early = 0;
        for (int c = 50; c < 167; c++) begin
            @(negedge clk);
            if (gnt != 2'b00) early++;
        end
        check("late/early_gnt", early, 0);
        @(negedge clk);
        check("late/gnt1", 32'(gnt), 32'd2);
        @(posedge clk); #1 req = 2'b00;
        k = 0;
        do begin @(negedge clk); k++; end while (busy && k < 400);
        check("late/idle", 32'(busy), 32'd0);

        // Reset in the middle of SHIFT aborts the frame
        @(posedge clk); #1 req = 2'b01; slv_next = FB'($urandom);
        @(negedge clk);
        check("abort/gnt", 32'(gnt), 32'd1);
        @(posedge clk); #1 req = 2'b00;
        repeat (79) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort/cs_n", 32'(cs_n), 32'd1);
        check("abort/sck", 32'(sck), 32'd1);
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/rxdata", 32'(rxd), 32'd0);
        check("abort/rxchan", 32'(rxch), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        rxcnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rxv) rxcnt++;
        end
        check("abort/no_rxvalid", rxcnt, 0);
        sw = FB'($urandom); w0 = FB'($urandom); w1 = FB'($urandom);
        run_frame("abort/after", 2'b11, w0, w1, sw, 2'b01, sw[DB-1:0], 1'b0, w0);
        mdl_last = 1'b0;

        // Randomized frames against the arbitration/data model
        for (int i = 0; i < 25; i++) begin
            rq = 2'($urandom_range(1, 3));
            w0 = FB'($urandom); w1 = FB'($urandom); sw = FB'($urandom);
            ch = (rq == 2'b11) ? ~mdl_last : rq[1];
            eg = ch ? 2'b10 : 2'b01;
            run_frame("rnd", rq, w0, w1, sw, eg, sw[DB-1:0], ch, ch ? w1 : w0);
            mdl_last = ch;
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        check("sck_idle_high", sck_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
